iir_sample_driver: RTL and testbench
====================================

Name: iir_sample_driver

Overview:
- Upstream stimulus/pacing stage for iir_hls_core. Generates a sample-rate tick and a periodic test waveform (impulse, step, square, zero).
- Drives x and ap_start under the ap_ctrl_hs handshake, and registers ap_return on ap_done as a valid-qualified output sample.
- Reports dropped ticks (core too slow) through a sticky overrun flag. Outputs feed the ILA.

Parameters:
- DATA_W, 20, sample width of x, ap_return and y (signed two's complement).
- TICK_DIV, 2, clk cycles per sample tick; must be >= 1.
- PERIOD, 1024, samples per waveform repeat; must be a power of two and >= 2.
- AMP, 20'h1_0000, positive stimulus amplitude.

Ports:
- clk  in  1  system clock; also drives the core's ap_clk.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request.
- mode  in  2  0 impulse, 1 step, 2 square, 3 zero.
- ap_start  out  1  to core.
- ap_ready  in  1  from core.
- ap_done  in  1  from core.
- ap_idle  in  1  from core; status only.
- x  out  DATA_W  core input sample.
- ap_return  in  DATA_W  core result.
- y  out  DATA_W  registered core result.
- y_valid  out  1  one-cycle strobe marking a new y.
- samp_index  out  $clog2(PERIOD)  index of the sample currently issued.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; set when a tick arrives outside WAIT_TICK.

Behaviour:
- Reset values (async, on rst high): ap_start=0, x=0, y=0, y_valid=0, samp_index=0, busy=0, overrun=0, state=IDLE, tick counter=0, latched mode=impulse. Reset mid-transaction drops the transaction. No late ap_done after reset may produce y_valid.
- Tick divider: free-running 0..TICK_DIV-1 while state!=IDLE. Pulses tick on wrap. Cleared on entering IDLE.
- FSM states: IDLE, WAIT_TICK, START, WAIT_DONE.
- IDLE -> WAIT_TICK when enable=1. samp_index is 0 on entry.
- WAIT_TICK -> START on tick. The same edge registers x from the waveform at samp_index. ap_start rises the cycle after the tick.
- START: ap_start=1 and x held stable until ap_ready=1. Then ap_start drops.
- START, ap_ready=1 with ap_done=0: go to WAIT_DONE.
- START, ap_ready=1 and ap_done=1 in the same cycle: capture and go to WAIT_TICK (or IDLE if enable=0).
- WAIT_DONE -> WAIT_TICK on ap_done; goes to IDLE instead if enable=0.
- Capture: on the ap_done cycle, y<=ap_return and y_valid=1 for exactly one cycle, the cycle after ap_done. ap_done outside START/WAIT_DONE is ignored.
- samp_index increments, wrapping PERIOD-1 -> 0, when ap_ready is accepted.
- mode is latched only when samp_index==0 at the tick. Mode changes mid-period take effect at the next period boundary.
- Waveforms, with h=PERIOD/2:
  - impulse: AMP at index 0, else 0.
  - step: 0 for index<h, else AMP.
  - square: AMP for index<h, else -AMP (20'hF_0000 at default).
  - zero: 0.
- Overrun: tick while state is START or WAIT_DONE sets overrun=1. That tick is dropped, not queued. Cleared only by rst.
- enable deassert: the in-flight transaction always completes, including capture, before entering IDLE. enable=0 in WAIT_TICK goes to IDLE immediately.
- Minimum latency: tick -> ap_start 1 cycle; ap_done -> y_valid 1 cycle.

Decomposition:
- iir_pkg holds: DATA_W localparam; typedef enum logic [1:0] mode_t {MODE_IMPULSE, MODE_STEP, MODE_SQUARE, MODE_ZERO}; typedef enum state_t for the FSM; signed sample typedef logic signed [DATA_W-1:0] samp_t.
- One sub-module, iir_rate_div: tick divider with clk, rst, clr, tick.
- Waveform selection is an inline function.

Test Plan:
1. TICK_DIV=8, PERIOD=4, impulse; core model asserts ap_ready with ap_start and ap_done 2 cycles later with ap_return=x+1 -> x sequence 10000,0,0,0,10000. ap_start high 1 cycle per 8. y=10001,1,1,1 with y_valid every 8 cycles.
2. Square, PERIOD=4 -> x=10000,10000,F0000,F0000 repeating. Step -> 0,0,10000,10000. overrun stays 0.
3. Core holds ap_ready low 10 cycles, TICK_DIV=8 -> x and ap_start stable throughout. overrun=1. Exactly one tick dropped. samp_index advances by 1 only.
4. mode switched impulse->square at samp_index=2 -> remaining samples in the period follow impulse (0,0). Square starts at the next index 0.
5. rst asserted in WAIT_DONE, then ap_done pulsed 2 cycles after release -> all outputs at reset values. y_valid never asserts.
6. enable dropped in WAIT_DONE; ap_done arrives 3 cycles later -> y_valid pulses once, then IDLE, busy=0, ap_start stays 0. Re-enable restarts at samp_index=0.
7. Core asserts ap_ready and ap_done in the same cycle -> single y_valid. FSM returns directly to WAIT_TICK.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types for the IIR stimulus driver: sample width, waveform modes, FSM states.
package iir_pkg;
  localparam int DATA_W = 20;

  typedef logic signed [DATA_W-1:0] samp_t;

  typedef enum logic [1:0] {
    MODE_IMPULSE,
    MODE_STEP,
    MODE_SQUARE,
    MODE_ZERO
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_START,
    ST_WAIT_DONE
  } state_t;
endpackage

// File: rtl/iir_sample_driver_if.sv
// ap_ctrl_hs link between the sample driver (master) and the HLS core (slave).
interface iir_sample_driver_if;
  import iir_pkg::*;

  logic  ap_start;
  logic  ap_ready;
  logic  ap_done;
  logic  ap_idle;
  samp_t x;
  samp_t ap_return;

  modport master (
    output ap_start, x,
    input  ap_ready, ap_done, ap_idle, ap_return
  );

  modport slave (
    input  ap_start, x,
    output ap_ready, ap_done, ap_idle, ap_return
  );
endinterface

// File: rtl/iir_rate_div.sv
// Sample-rate divider: counts 0..TICK_DIV-1 while not cleared, tick is high on the last count.
module iir_rate_div #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == LAST);
endmodule

// File: rtl/iir_sample_driver.sv
// Paces samples into iir_hls_core on a divided tick, issuing a periodic test waveform,
// capturing ap_return as a one-cycle y_valid strobe and flagging ticks lost while busy.
module iir_sample_driver
  import iir_pkg::*;
#(
  parameter int                TICK_DIV = 2,
  parameter int                PERIOD   = 1024,
  parameter logic [DATA_W-1:0] AMP      = 20'h1_0000,
  localparam int               IW       = $clog2(PERIOD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  mode_t                mode,
  iir_sample_driver_if.master  core,
  output samp_t                y,
  output logic                 y_valid,
  output logic [IW-1:0]        samp_index,
  output logic                 busy,
  output logic                 overrun
);
  state_t        state_q;
  logic          ap_start_q;
  samp_t         x_q;
  samp_t         y_q;
  logic          y_valid_q;
  logic [IW-1:0] idx_q;
  logic          overrun_q;
  mode_t         mode_q;
  mode_t         mode_sel;
  logic          tick;
  logic          unused_idle;

  // PERIOD is a power of two, so the index MSB marks the upper half-period.
  function automatic samp_t wave(input mode_t m, input logic [IW-1:0] idx);
    samp_t amp_s;
    amp_s = samp_t'(AMP);
    case (m)
      MODE_IMPULSE: wave = (idx == '0) ? amp_s : '0;
      MODE_STEP:    wave = idx[IW-1] ? amp_s : '0;
      MODE_SQUARE:  wave = idx[IW-1] ? -amp_s : amp_s;
      default:      wave = '0;
    endcase
  endfunction

  iir_rate_div #(.TICK_DIV(TICK_DIV)) u_rate_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  // A new mode is only admitted at the period boundary.
  assign mode_sel = (idx_q == '0) ? mode : mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ap_start_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
      mode_q     <= MODE_IMPULSE;
    end else begin
      y_valid_q <= 1'b0;
      if (tick && ((state_q == ST_START) || (state_q == ST_WAIT_DONE))) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_WAIT_TICK;
            idx_q   <= '0;
          end
        end
        ST_WAIT_TICK: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            state_q    <= ST_START;
            ap_start_q <= 1'b1;
            x_q        <= wave(mode_sel, idx_q);
            mode_q     <= mode_sel;
          end
        end
        ST_START: begin
          if (core.ap_ready) begin
            ap_start_q <= 1'b0;
            idx_q      <= idx_q + 1'b1;
            if (core.ap_done) begin
              y_q       <= core.ap_return;
              y_valid_q <= 1'b1;
              state_q   <= enable ? ST_WAIT_TICK : ST_IDLE;
            end else begin
              state_q <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (core.ap_done) begin
            y_q       <= core.ap_return;
            y_valid_q <= 1'b1;
            state_q   <= enable ? ST_WAIT_TICK : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core.ap_start = ap_start_q;
  assign core.x        = x_q;
  assign y             = y_q;
  assign y_valid       = y_valid_q;
  assign samp_index    = idx_q;
  assign busy          = (state_q != ST_IDLE);
  assign overrun       = overrun_q;
  assign unused_idle   = core.ap_idle;
endmodule

// File: tb/tb_iir_sample_driver.sv
// Randomized bench: reactive core model plus a sample-level reference for x, y, pacing and flags.
module tb_iir_sample_driver;
  import iir_pkg::*;

  localparam int                TICK_DIV = 8;
  localparam int                PERIOD   = 4;
  localparam logic [DATA_W-1:0] AMP      = 20'h1_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  mode_t       mode_r = MODE_IMPULSE;
  samp_t       y;
  logic        y_valid;
  logic [1:0]  samp_index;
  logic        busy;
  logic        overrun;

  iir_sample_driver_if bus();

  iir_sample_driver #(.TICK_DIV(TICK_DIV), .PERIOD(PERIOD), .AMP(AMP)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode_r),
    .core       (bus),
    .y          (y),
    .y_valid    (y_valid),
    .samp_index (samp_index),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ready_delay = 0;
  int          done_delay = 2;
  int          rdy_wait = 0;
  int          done_cnt = 0;
  int          m_idx = 0;
  int          last_rise = -1;
  int          exp_gap = TICK_DIV;
  int          yv_seen = 0;
  logic        gap_on = 1'b1;
  logic        yv_pend = 1'b0;
  logic        ready_drv = 1'b0;
  logic        start_prev = 1'b0;
  logic        accepted_now = 1'b0;
  mode_t       m_mode = MODE_IMPULSE;
  logic [19:0] cur_exp = '0;
  logic [19:0] x_hold = '0;
  logic [19:0] core_ret = '0;
  logic [19:0] exp_y[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_wave(input mode_t m, input int idx);
    logic [19:0] neg_amp;
    neg_amp = 20'd0 - AMP;
    case (m)
      MODE_IMPULSE: return (idx == 0) ? AMP : 20'd0;
      MODE_STEP:    return (idx < PERIOD / 2) ? 20'd0 : AMP;
      MODE_SQUARE:  return (idx < PERIOD / 2) ? AMP : neg_amp;
      default:      return 20'd0;
    endcase
  endfunction

  // One clock: observe at the falling edge, then let the core model respond.
  task automatic step();
    @(negedge clk);
    cyc++;
    accepted_now = 1'b0;
    chk("y_valid", {31'd0, y_valid}, {31'd0, yv_pend});
    if (y_valid) yv_seen++;
    if (yv_pend) chk("y", {12'd0, $unsigned(y)}, {12'd0, exp_y.pop_front()});
    yv_pend = 1'b0;
    if (bus.ap_start && !start_prev) begin
      if (m_idx == 0) m_mode = mode_r;
      cur_exp = ref_wave(m_mode, m_idx);
      chk("x", {12'd0, $unsigned(bus.x)}, {12'd0, cur_exp});
      chk("samp_index", {30'd0, samp_index}, m_idx);
      if (gap_on && last_rise >= 0) chk("tick_gap", cyc - last_rise, exp_gap);
      exp_gap = TICK_DIV;
      last_rise = cyc;
      x_hold = $unsigned(bus.x);
    end else if (bus.ap_start && start_prev) begin
      chk("x_hold", {12'd0, $unsigned(bus.x)}, {12'd0, x_hold});
    end else if (!bus.ap_start && start_prev) begin
      chk("start_drop", {31'd0, ready_drv}, 32'd1);
    end
    start_prev = bus.ap_start;
    ready_drv = 1'b0;
    bus.ap_ready = 1'b0;
    bus.ap_done = 1'b0;
    if (bus.ap_start) begin
      if (rdy_wait >= ready_delay) begin
        bus.ap_ready = 1'b1;
        ready_drv = 1'b1;
        accepted_now = 1'b1;
        rdy_wait = 0;
        exp_y.push_back(cur_exp + 20'd1);
        m_idx = (m_idx + 1) % PERIOD;
        core_ret = $unsigned(bus.x) + 20'd1;
        if (done_delay == 0) begin
          bus.ap_done = 1'b1;
          bus.ap_return = samp_t'(core_ret);
          yv_pend = 1'b1;
        end else begin
          done_cnt = done_delay;
        end
      end else begin
        rdy_wait++;
      end
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        bus.ap_done = 1'b1;
        bus.ap_return = samp_t'(core_ret);
        yv_pend = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_accept(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted_now && n < budget);
    chk("accept_wait", {31'd0, accepted_now}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ap_start"}, {31'd0, bus.ap_start}, 32'd0);
    chk({tag, "_x"}, {12'd0, $unsigned(bus.x)}, 32'd0);
    chk({tag, "_y"}, {12'd0, $unsigned(y)}, 32'd0);
    chk({tag, "_y_valid"}, {31'd0, y_valid}, 32'd0);
    chk({tag, "_samp_index"}, {30'd0, samp_index}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  task automatic model_clear();
    exp_y.delete();
    yv_pend = 1'b0;
    ready_drv = 1'b0;
    start_prev = 1'b0;
    rdy_wait = 0;
    done_cnt = 0;
    m_idx = 0;
    m_mode = MODE_IMPULSE;
    last_rise = -1;
    bus.ap_ready = 1'b0;
    bus.ap_done = 1'b0;
  endtask

  initial begin
    bus.ap_ready = 1'b0;
    bus.ap_done = 1'b0;
    bus.ap_idle = 1'b1;
    bus.ap_return = '0;
    run(3);
    chk_reset_vals("rst0");
    rst = 1'b0;
    run(2);
    chk_reset_vals("idle");

    // Impulse pacing, one sample per TICK_DIV cycles.
    enable = 1'b1;
    run(TICK_DIV * PERIOD * 2 + 4);
    chk("busy_run", {31'd0, busy}, 32'd1);

    // Square then step over whole periods.
    mode_r = MODE_SQUARE;
    run(TICK_DIV * PERIOD * 3);
    mode_r = MODE_STEP;
    run(TICK_DIV * PERIOD * 3);
    chk("overrun_clean", {31'd0, overrun}, 32'd0);

    // Mid-period mode change is deferred to the next boundary.
    mode_r = MODE_IMPULSE;
    run(TICK_DIV * PERIOD);
    for (int k = 0; k < 8 && m_idx != 2; k++) wait_accept(TICK_DIV * 2);
    chk("mid_idx", m_idx, 32'd2);
    mode_r = MODE_SQUARE;
    run(TICK_DIV * PERIOD * 2);

    // ap_ready and ap_done in the same cycle.
    done_delay = 0;
    run(TICK_DIV * PERIOD * 2);
    chk("overrun_same", {31'd0, overrun}, 32'd0);

    // Randomized modes and core response times within one tick period.
    for (int i = 0; i < 500; i++) begin
      step();
      if ($urandom_range(0, 15) == 0) mode_r = mode_t'($urandom_range(0, 3));
      if (accepted_now) begin
        ready_delay = $urandom_range(0, 3);
        done_delay = $urandom_range(0, 3);
      end
    end
    chk("overrun_rand", {31'd0, overrun}, 32'd0);

    // Slow core: ready held off for 10 cycles drops exactly one tick.
    wait_accept(TICK_DIV * 2);
    ready_delay = 10;
    done_delay = 2;
    wait_accept(TICK_DIV * 4);
    ready_delay = 0;
    exp_gap = 2 * TICK_DIV;
    run(4);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    run(TICK_DIV * PERIOD * 2);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // enable dropped while waiting for ap_done.
    done_delay = 4;
    wait_accept(TICK_DIV * 2);
    step();
    enable = 1'b0;
    yv_seen = 0;
    run(12);
    chk("drain_yv_count", yv_seen, 32'd1);
    chk("drain_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("drain_ap_start", {31'd0, bus.ap_start}, 32'd0);
    end
    enable = 1'b1;
    m_idx = 0;
    last_rise = -1;
    done_delay = 2;
    mode_r = MODE_SQUARE;
    run(TICK_DIV * PERIOD * 2);

    // Reset while in WAIT_DONE, then a stale ap_done after release.
    done_delay = 1000;
    wait_accept(TICK_DIV * 2);
    step();
    rst = 1'b1;
    enable = 1'b0;
    model_clear();
    #1;
    chk_reset_vals("rst_mid");
    step();
    rst = 1'b0;
    done_delay = 2;
    run(2);
    bus.ap_done = 1'b1;
    bus.ap_return = samp_t'($urandom);
    yv_seen = 0;
    run(10);
    chk("stale_yv_count", yv_seen, 32'd0);
    chk_reset_vals("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
